// File: rtl/iiitb_sdg.sv
// Serial pattern generator: loads a parallel word and shifts it out MSB-first,
// repeating it a programmable number of times. Define SDG_PARITY_EN to append an even-parity bit.
module iiitb_sdg #(
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [CNT_W-1:0]  repeat_cnt_i,
  output logic              load_ready_o,
  output logic              dout_o,
  output logic              dout_valid_o,
  output logic              frame_done_o,
  output logic              busy_o
);

`ifdef SDG_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int              BCW      = $clog2(FRAME_LEN);
  localparam logic [BCW-1:0]  LAST_POS = BCW'(FRAME_LEN - 1);
  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               fdone_q, fdone_d;
  logic               busy_q, busy_d;

  logic [FRAME_LEN-1:0] frame_w;
  logic [BCW-1:0]       bit_nxt;

  // Position FRAME_LEN-1 is the pattern MSB; position 0 is the last bit sent.
`ifdef SDG_PARITY_EN
  assign frame_w = {word_q, ^word_q};
`else
  assign frame_w = word_q;
`endif

  assign bit_nxt = bit_q - 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fdone_q <= fdone_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are computed for the bit that will be on the line after the next edge.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    fdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          word_d  = load_data_i;
          rem_d   = (repeat_cnt_i == '0) ? CNT_W'(1) : repeat_cnt_i;
          bit_d   = LAST_POS;
          state_d = SHIFT;
          valid_d = 1'b1;
          dout_d  = load_data_i[DATA_W-1];
        end
      end

      SHIFT: begin
        if (bit_q != '0) begin
          bit_d   = bit_nxt;
          valid_d = 1'b1;
          dout_d  = frame_w[bit_nxt];
          fdone_d = (bit_nxt == '0);
        end else begin
          rem_d = rem_q - 1'b1;
          if (rem_q > CNT_W'(1)) begin
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_INIT;
            end else begin
              bit_d   = LAST_POS;
              valid_d = 1'b1;
              dout_d  = frame_w[LAST_POS];
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = SHIFT;
          bit_d   = LAST_POS;
          valid_d = 1'b1;
          dout_d  = frame_w[LAST_POS];
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  assign load_ready_o = (state_q == IDLE);
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign frame_done_o = fdone_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/iiitb_sdg.md
Name: iiitb_sdg

Overview:
- Serial pattern generator; the transmit-side counterpart to the serial sequence detector.
- Accepts a parallel pattern word through a valid/ready load handshake.
- Shifts the word out MSB-first on a single-bit line, one bit per clock, with a programmable repeat count and optional idle gap between frames.
- Drives detector `din` directly in loopback benches and in the top-level pattern-source path.

Parameters:
- DATA_W, 4, pattern width in bits (≥2).
- CNT_W, 8, width of the repeat counter.
- GAP_CYCLES, 0, idle cycles (dout=0, dout_valid=0) inserted between repeated frames; 0 = back-to-back.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  new pattern offered.
- load_data  input  DATA_W  pattern word, MSB transmitted first.
- repeat_cnt  input  CNT_W  number of frames to send; 0 treated as 1.
- load_ready  output  1  block can accept a pattern.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a pattern bit this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last bit of each frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs except load_ready are registered.
- load_ready is decoded as (state==IDLE).
- Reset (async, while reset=0):
  - state=IDLE; shift register, bit counter, repeat counter and gap counter cleared.
  - dout=0, dout_valid=0, frame_done=0, busy=0, load_ready=1.
- Reset mid-frame aborts immediately; no partial-frame completion after release.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Accept on the edge where load_valid && load_ready.
  - Capture load_data into the shift register.
  - Capture max(repeat_cnt,1) into the remaining-frame counter.
  - Go to SHIFT.
- Latency: the first bit (load_data[DATA_W-1]) appears on dout with dout_valid=1 in the first cycle after the accepting edge.
- SHIFT:
  - Emit one bit per cycle, MSB first, for DATA_W cycles.
  - The original word is retained for repeats; shift a copy, or index with a bit counter.
  - On the last bit: frame_done=1, remaining counter decrements.
- After the last bit of a frame:
  - Remaining frames >0 and GAP_CYCLES>0 → GAP.
  - Remaining frames >0 and GAP_CYCLES=0 → next frame's MSB follows in the very next cycle, with no bubble.
  - Remaining frames =0 → IDLE; load_ready=1 in the cycle after the last bit.
- GAP: hold dout=0, dout_valid=0, busy=1 for exactly GAP_CYCLES cycles, then SHIFT.
- When dout_valid=0, dout is forced to 0.
- load_valid while busy: ignored, not queued.
- A new load is accepted the cycle after the final frame_done at the earliest, so back-to-back patterns have a one-cycle bubble.
- repeat_cnt = 2^CNT_W−1 is legal: the counter must not wrap before reaching 0.

Optional Feature:
- Macro: SDG_PARITY_EN.
- When defined:
  - Each frame is DATA_W+1 bits.
  - The extra final bit is the even parity (XOR) of the pattern word.
  - frame_done pulses on the parity bit.
  - dout_valid stays high through the parity bit.
- When undefined: frames are exactly DATA_W bits; no parity logic is synthesized.

Test Plan:
- Load 4'b1010, repeat_cnt=1 → dout=1,0,1,0 in cycles 1-4 after accept; dout_valid high for 4 cycles; frame_done in cycle 4; load_ready=1 in cycle 5.
- Load 4'b1010, repeat_cnt=3, GAP_CYCLES=0, looped into the sequence detector → dout 101010101010 contiguous; 3 frame_done pulses spaced 4 cycles apart; detector y asserts on each completed (overlapping) 1010.
- GAP_CYCLES=2, load 4'b1100, repeat_cnt=2 → 1,1,0,0, then 2 cycles dout_valid=0, then 1,1,0,0; busy high throughout; repeat_cnt=0 yields exactly one frame.
- Pulse reset low for 3 cycles during the 2nd bit → dout/dout_valid/busy drop to 0 immediately; load_ready=1; after release no further bits without a new load.
- Hold load_valid=1 with load_data=4'b0110 throughout a frame of 4'b1010 → transmits 1010 only; 0110 is accepted in the cycle load_ready returns and starts the next cycle.
- With SDG_PARITY_EN defined, load 4'b1011 → dout=1,0,1,1,1; frame_done on bit 5. With 4'b1001 → parity bit 0.
